// File: rtl/elbeth_csr_host_port.sv
// elbeth_csr_host_port - host initiator onto the CSR file access port, arbitrated against the pipeline
// Core path is a zero-latency mux; host path is a single queued access with a starvation guard.
module elbeth_csr_host_port #(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic [1:0]  host_req_op,
    input  logic [11:0] host_req_addr,
    input  logic [31:0] host_req_wdata,
    output logic        host_resp_valid,
    input  logic        host_resp_ready,
    output logic [31:0] host_resp_rdata,
    output logic        host_resp_err,
    input  logic [2:0]  core_cmd,
    input  logic [11:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic        core_exception,
    input  logic        core_eret,
    output logic        core_stall,
    output logic [2:0]  csr_cmd,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    input  logic        csr_illegal_access
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        stall_q, stall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        grant;
    logic        ro_fault;
    logic [2:0]  host_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            stall_q      <= 1'b0;
            cnt_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            stall_q      <= stall_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // A stalled core has already yielded, so only exception/eret can still block the host.
    assign grant    = (state_q == S_WAIT) & ~core_exception & ~core_eret & (stall_q | ~core_cmd[2]);
    assign ro_fault = (op_q != 2'b00) & (addr_q[11:10] == 2'b11);
    assign host_cmd = ro_fault ? 3'b100 : {1'b1, op_q};

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        stall_d      = stall_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (host_req_valid && req_ready_q) begin
                    op_d        = host_req_op;
                    addr_d      = host_req_addr;
                    wdata_d     = host_req_wdata;
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (grant) begin
                    resp_rdata_d = csr_rdata;
                    resp_err_d   = csr_illegal_access | ro_fault;
                    resp_valid_d = 1'b1;
                    stall_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_RESP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        stall_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (host_resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csr_cmd   = core_cmd;
        csr_addr  = core_addr;
        csr_wdata = core_wdata;
        if (grant) begin
            csr_cmd   = host_cmd;
            csr_addr  = addr_q;
            csr_wdata = wdata_q;
        end else if (stall_q) begin
            csr_cmd = 3'b000;
        end
    end

    assign host_req_ready  = req_ready_q;
    assign host_resp_valid = resp_valid_q;
    assign host_resp_rdata = resp_rdata_q;
    assign host_resp_err   = resp_err_q;
    assign core_stall      = stall_q;

endmodule

// File: tb/tb_elbeth_csr_host_port.sv
// tb/tb_elbeth_csr_host_port.sv - vector table, corner sequences and random host traffic against a CSR model
module tb_elbeth_csr_host_port;

    logic        clk;
    logic        rst;
    logic        host_req_valid;
    logic        host_req_ready;
    logic [1:0]  host_req_op;
    logic [11:0] host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_resp_valid;
    logic        host_resp_ready;
    logic [31:0] host_resp_rdata;
    logic        host_resp_err;
    logic [2:0]  core_cmd;
    logic [11:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_exception;
    logic        core_eret;
    logic        core_stall;
    logic [2:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal_access;

    elbeth_csr_host_port dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
        .host_resp_rdata(host_resp_rdata), .host_resp_err(host_resp_err),
        .core_cmd(core_cmd), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_exception(core_exception), .core_eret(core_eret), .core_stall(core_stall),
        .csr_cmd(csr_cmd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal_access(csr_illegal_access)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: 0x8xx undefined, everything else writable
    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [2:0]  last_grant_cmd;
    bit          core_rand;
    int          vec_count;
    int          miscompares;

    function automatic logic illegal_addr(input logic [11:0] a);
        return a[11:8] == 4'h8;
    endfunction

    assign csr_rdata          = csr_mem[csr_addr];
    assign csr_illegal_access = illegal_addr(csr_addr);

    always @(posedge clk) begin
        if (!rst && csr_cmd[2] && !illegal_addr(csr_addr)) begin
            case (csr_cmd[1:0])
                2'b01:   csr_mem[csr_addr] <= csr_wdata;
                2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
                2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
                default: ;
            endcase
        end
        if (!rst && core_cmd == 3'b000 && csr_cmd != 3'b000) last_grant_cmd <= csr_cmd;
    end

    task automatic preset(input logic [11:0] a, input logic [31:0] v);
        csr_mem[a] <= v;
        ref_mem[a] = v;
    endtask

    // Spec-level outcome of one host access; updates the reference CSR image
    task automatic ref_access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
        rd  = ref_mem[a];
        err = illegal_addr(a) || (op != 2'b00 && a[11:10] == 2'b11);
        if (!err) begin
            case (op)
                2'b01:   ref_mem[a] = wd;
                2'b10:   ref_mem[a] = ref_mem[a] | wd;
                2'b11:   ref_mem[a] = ref_mem[a] & ~wd;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (core_rand) begin
            core_cmd       = ($urandom_range(0, 1) == 1) ? 3'b100 : {1'b0, 2'($urandom_range(0, 3))};
            core_addr      = 12'($urandom);
            core_wdata     = $urandom;
            core_exception = ($urandom_range(0, 9) == 0);
            core_eret      = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic host_txn(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int lat, output bit timeout);
        int n;
        n = 0;
        timeout = 0;
        lat = 0;
        rd = '0;
        err = 1'b0;
        while (!host_req_ready && n < 300) begin tick(); n++; end
        if (!host_req_ready) begin
            timeout = 1;
        end else begin
            host_req_valid = 1'b1;
            host_req_op    = op;
            host_req_addr  = a;
            host_req_wdata = wd;
            tick();
            // keep junk valid during WAIT: must be ignored
            host_req_addr  = ~a;
            host_req_wdata = ~wd;
            while (!host_resp_valid && lat < 300) begin tick(); lat++; end
            host_req_valid = 1'b0;
            if (!host_resp_valid) begin
                timeout = 1;
            end else begin
                rd  = host_resp_rdata;
                err = host_resp_err;
                host_resp_ready = 1'b1;
                tick();
                host_resp_ready = 1'b0;
            end
        end
    endtask

    typedef struct {
        bit          pre_en;
        logic [31:0] pre_val;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [2:0]  exp_cmd;
        logic [31:0] exp_after;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rd, exp_rd, held;
        logic        err, exp_err;
        int          lat;
        bit          to;
        logic [11:0] addr_set[6];

        vecs[0]  = '{1, 32'hDEADBEEF, 2'b00, 12'h340, 32'h0,        32'hDEADBEEF, 0, 3'b100, 32'hDEADBEEF};
        vecs[1]  = '{1, 32'h000000F0, 2'b10, 12'h340, 32'h0F,       32'h000000F0, 0, 3'b110, 32'h000000FF};
        vecs[2]  = '{0, 32'h0,        2'b00, 12'h340, 32'h0,        32'h000000FF, 0, 3'b100, 32'h000000FF};
        vecs[3]  = '{0, 32'h0,        2'b11, 12'h340, 32'hF0,       32'h000000FF, 0, 3'b111, 32'h0000000F};
        vecs[4]  = '{0, 32'h0,        2'b00, 12'h340, 32'h0,        32'h0000000F, 0, 3'b100, 32'h0000000F};
        vecs[5]  = '{1, 32'hC0DE0001, 2'b01, 12'hF00, 32'h1234,     32'hC0DE0001, 1, 3'b100, 32'hC0DE0001};
        vecs[6]  = '{1, 32'h00000100, 2'b10, 12'hC12, 32'hFF,       32'h00000100, 1, 3'b100, 32'h00000100};
        vecs[7]  = '{1, 32'h0,        2'b01, 12'h305, 32'hA5A5A5A5, 32'h0,        0, 3'b101, 32'hA5A5A5A5};
        vecs[8]  = '{0, 32'h0,        2'b00, 12'h305, 32'h0,        32'hA5A5A5A5, 0, 3'b100, 32'hA5A5A5A5};
        vecs[9]  = '{1, 32'h00000077, 2'b01, 12'h800, 32'h55,       32'h00000077, 1, 3'b101, 32'h00000077};
        vecs[10] = '{1, 32'hFFFFFFFF, 2'b11, 12'hBFF, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 3'b111, 32'hF0F0F0F0};
        addr_set = '{12'h340, 12'h305, 12'hF00, 12'hC01, 12'h800, 12'h7FF};

        vec_count = 0;
        miscompares = 0;
        core_rand = 0;
        for (int i = 0; i < 4096; i++) begin
            csr_mem[i] <= 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b0;
        host_req_valid = 1'b0; host_req_op = 2'b00; host_req_addr = '0; host_req_wdata = '0;
        host_resp_ready = 1'b0;
        core_cmd = 3'b101; core_addr = 12'h123; core_wdata = 32'hCAFE;
        core_exception = 1'b0; core_eret = 1'b0;

        // reset state and core passthrough
        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", host_req_ready, 0);
        chk("rst_resp_valid", host_resp_valid, 0);
        chk("rst_resp_rdata", host_resp_rdata, 0);
        chk("rst_resp_err", host_resp_err, 0);
        chk("rst_core_stall", core_stall, 0);
        chk("rst_pass_cmd", csr_cmd, 3'b101);
        chk("rst_pass_addr", csr_addr, 12'h123);
        chk("rst_pass_wdata", csr_wdata, 32'hCAFE);
        @(posedge clk); @(posedge clk); #1;
        core_cmd = 3'b000;
        rst = 1'b0;
        #1 chk("ready_before_edge", host_req_ready, 0);
        tick();
        chk("ready_after_edge", host_req_ready, 1);

        // table vectors with idle core
        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preset(vecs[i].addr, vecs[i].pre_val);
            ref_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err);
            host_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, err, lat, to);
            chk($sformatf("v%0d_timeout", i), 32'(to), 0);
            chk($sformatf("v%0d_latency", i), lat, 1);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("v%0d_grant_cmd", i), last_grant_cmd, vecs[i].exp_cmd);
            chk($sformatf("v%0d_csr_after", i), csr_mem[vecs[i].addr], vecs[i].exp_after);
        end

        // starvation: core reads every cycle
        core_cmd = 3'b100; core_addr = 12'h305; core_wdata = 32'h11;
        ref_access(2'b00, 12'h340, 32'h0, exp_rd, exp_err);
        host_req_valid = 1'b1; host_req_op = 2'b00; host_req_addr = 12'h340;
        tick();
        host_req_valid = 1'b0;
        chk("starve_pass_cmd", csr_cmd, 3'b100);
        chk("starve_pass_addr", csr_addr, 12'h305);
        for (int i = 0; i < 15; i++) tick();
        chk("starve_stall_15", core_stall, 0);
        chk("starve_pass_wdata", csr_wdata, 32'h11);
        tick();
        chk("starve_stall_16", core_stall, 1);
        core_exception = 1'b1;
        #1;
        chk("starve_exc_cmd", csr_cmd, 3'b000);
        chk("starve_exc_addr", csr_addr, 12'h305);
        tick();
        chk("starve_exc_hold_stall", core_stall, 1);
        chk("starve_exc_no_resp", host_resp_valid, 0);
        core_exception = 1'b0;
        #1;
        chk("starve_grant_cmd", csr_cmd, 3'b100);
        chk("starve_grant_addr", csr_addr, 12'h340);
        tick();
        chk("starve_resp_valid", host_resp_valid, 1);
        chk("starve_stall_released", core_stall, 0);
        chk("starve_rdata", host_resp_rdata, exp_rd);
        host_resp_ready = 1'b1;
        tick();
        host_resp_ready = 1'b0;
        chk("starve_resp_done", host_resp_valid, 0);

        // exception held three WAIT cycles, then response backpressure
        core_cmd = 3'b000; core_exception = 1'b1;
        ref_access(2'b00, 12'h340, 32'h0, exp_rd, exp_err);
        host_req_valid = 1'b1; host_req_addr = 12'h340;
        tick();
        host_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("exc_no_grant_cmd%0d", i), csr_cmd, 3'b000);
            tick();
            chk($sformatf("exc_no_resp%0d", i), host_resp_valid, 0);
        end
        core_exception = 1'b0;
        #1 chk("exc_grant_cmd", csr_cmd, 3'b100);
        tick();
        chk("exc_resp_valid", host_resp_valid, 1);
        chk("exc_rdata", host_resp_rdata, exp_rd);
        held = host_resp_rdata;
        preset(12'h340, 32'h13579BDF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i), host_resp_valid, 1);
            chk($sformatf("bp_rdata%0d", i), host_resp_rdata, held);
            chk($sformatf("bp_err%0d", i), host_resp_err, 0);
            chk($sformatf("bp_ready%0d", i), host_req_ready, 0);
        end
        host_resp_ready = 1'b1;
        tick();
        host_resp_ready = 1'b0;
        chk("bp_valid_drop", host_resp_valid, 0);
        chk("bp_ready_rise", host_req_ready, 1);

        // reset during WAIT with stall raised
        core_cmd = 3'b100; core_addr = 12'h7FF; core_exception = 1'b1;
        host_req_valid = 1'b1; host_req_op = 2'b01; host_req_addr = 12'h340; host_req_wdata = 32'h99;
        tick();
        host_req_valid = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        chk("rstw_stall_up", core_stall, 1);
        chk("rstw_cmd_blocked", csr_cmd, 3'b000);
        #2 rst = 1'b1;
        #1;
        chk("rstw_stall", core_stall, 0);
        chk("rstw_ready", host_req_ready, 0);
        chk("rstw_resp_valid", host_resp_valid, 0);
        chk("rstw_cmd_pass", csr_cmd, 3'b100);
        chk("rstw_addr_pass", csr_addr, 12'h7FF);
        tick();
        rst = 1'b0; core_exception = 1'b0; core_cmd = 3'b000;
        tick();
        chk("rstw_ready_back", host_req_ready, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("rstw_no_resp", host_resp_valid, 0);
        chk("rstw_dropped_write", csr_mem[12'h340], ref_mem[12'h340]);

        // random host traffic against the reference model
        core_rand = 1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [11:0] ra;
            logic [31:0] rw;
            rop = 2'($urandom_range(0, 3));
            ra  = addr_set[$urandom_range(0, 5)];
            rw  = $urandom;
            ref_access(rop, ra, rw, exp_rd, exp_err);
            host_txn(rop, ra, rw, rd, err, lat, to);
            chk($sformatf("r%0d_timeout", i), 32'(to), 0);
            chk($sformatf("r%0d_rdata", i), rd, exp_rd);
            chk($sformatf("r%0d_err", i), err, exp_err);
        end
        core_rand = 0;
        core_cmd = 3'b000; core_exception = 1'b0; core_eret = 1'b0;
        tick();
        foreach (addr_set[i]) chk($sformatf("final_mem_%h", addr_set[i]), csr_mem[addr_set[i]], ref_mem[addr_set[i]]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
